// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master
// Brief    : Single-outstanding AXI4 initiator turning core load/store
//            requests into single-beat read/write transactions.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
   parameter logic [3:0] ID = 4'h0
) (
   input  logic        clk,
   input  logic        rst,
   // core request / response
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   // AXI read address
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [3:0]  arid,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   // AXI read data
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic [3:0]  rid,
   input  logic        rlast,
   // AXI write address
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] awaddr,
   output logic [3:0]  awid,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   // AXI write data
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   // AXI write response
   input  logic        bvalid,
   output logic        bready,
   input  logic [1:0]  bresp,
   input  logic [3:0]  bid
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WRITE = 3'd3,
      WRESP = 3'd4,
      RESP  = 3'd5
   } state_t;

   state_t r_state;
   logic   r_aw_done;
   logic   r_w_done;

   logic   w_aw_fire;
   logic   w_w_fire;
   logic   w_aw_complete;
   logic   w_w_complete;
   logic   w_unused;

   // Single-beat, 4-byte, INCR transfers only
   assign arid    = ID;
   assign arlen   = 8'd0;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign awid    = ID;
   assign awlen   = 8'd0;
   assign awsize  = 3'b010;
   assign awburst = 2'b01;

   assign w_aw_fire     = awvalid & awready;
   assign w_w_fire      = wvalid & wready;
   assign w_aw_complete = r_aw_done | w_aw_fire;
   assign w_w_complete  = r_w_done | w_w_fire;

   // Only the error bit of the response code matters; EXOKAY counts as success
   assign w_unused = &{1'b0, rresp[0], bresp[0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         arvalid    <= 1'b0;
         araddr     <= 32'd0;
         rready     <= 1'b0;
         awvalid    <= 1'b0;
         awaddr     <= 32'd0;
         wvalid     <= 1'b0;
         wdata      <= 32'd0;
         wstrb      <= 4'd0;
         wlast      <= 1'b0;
         bready     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (req_wen) begin
                     awvalid   <= 1'b1;
                     awaddr    <= req_addr;
                     wvalid    <= 1'b1;
                     wlast     <= 1'b1;
                     wdata     <= req_wdata;
                     wstrb     <= req_wstrb;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                     r_state   <= WRITE;
                  end else begin
                     arvalid <= 1'b1;
                     araddr  <= req_addr;
                     r_state <= RADDR;
                  end
               end
            end

            RADDR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  r_state <= RDATA;
               end
            end

            RDATA: begin
               if (rvalid) begin
                  rready     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_rdata <= rdata;
                  resp_err   <= rresp[1] | (rid != ID) | ~rlast;
                  r_state    <= RESP;
               end
            end

            WRITE: begin
               // AW and W channels retire independently, in any order
               if (w_aw_fire) begin
                  awvalid   <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_fire) begin
                  wvalid   <= 1'b0;
                  wlast    <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_complete && w_w_complete) begin
                  bready  <= 1'b1;
                  r_state <= WRESP;
               end
            end

            WRESP: begin
               if (bvalid) begin
                  bready     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_rdata <= 32'd0;
                  resp_err   <= bresp[1] | (bid != ID);
                  r_aw_done  <= 1'b0;
                  r_w_done   <= 1'b0;
                  r_state    <= RESP;
               end
            end

            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_rdata <= 32'd0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
                  r_state    <= IDLE;
               end
            end

            default: begin
               r_state    <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               arvalid    <= 1'b0;
               rready     <= 1'b0;
               awvalid    <= 1'b0;
               wvalid     <= 1'b0;
               wlast      <= 1'b0;
               bready     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_master
// Brief    : Directed, table-driven bench for axi_lite_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready, rlast;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [3:0]  rid;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready, wlast;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   axi_lite_master #(.ID(4'h0)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rid(rid), .rlast(rlast),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
   );

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [3:0]  strb;
      logic [31:0] sdata;   // slave read data
      logic [1:0]  sresp;   // slave rresp/bresp
      logic [3:0]  sid;     // slave rid/bid
      logic        slast;   // slave rlast
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic idle_inputs();
      req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
      resp_ready = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0;
      rlast = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
   endtask

   // Zero-wait slave, cycle-exact latency checks; called at a negedge in IDLE
   task automatic run_vec(input int i);
      vec_t v;
      v = vecs[i];
      req_valid = 1; req_wen = v.wen; req_addr = v.addr;
      req_wdata = v.wdat; req_wstrb = v.strb;
      @(negedge clk);                     // accepted at edge T
      req_valid = 0;
      check($sformatf("v%0d req_ready low", i), req_ready, 0);
      if (!v.wen) begin
         check($sformatf("v%0d arvalid", i), arvalid, 1);
         check($sformatf("v%0d araddr", i), araddr, v.addr);
         check($sformatf("v%0d awvalid idle", i), awvalid, 0);
         arready = 1;
         @(negedge clk);                  // AR fires at T+1
         arready = 0;
         check($sformatf("v%0d arvalid drop", i), arvalid, 0);
         check($sformatf("v%0d rready", i), rready, 1);
         rvalid = 1; rdata = v.sdata; rresp = v.sresp; rid = v.sid; rlast = v.slast;
         @(negedge clk);                  // R fires at T+2
         rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
         check($sformatf("v%0d rready drop", i), rready, 0);
      end else begin
         check($sformatf("v%0d awvalid", i), awvalid, 1);
         check($sformatf("v%0d wvalid", i), wvalid, 1);
         check($sformatf("v%0d wlast", i), wlast, 1);
         check($sformatf("v%0d awaddr", i), awaddr, v.addr);
         check($sformatf("v%0d wdata", i), wdata, v.wdat);
         check($sformatf("v%0d wstrb", i), wstrb, v.strb);
         check($sformatf("v%0d arvalid idle", i), arvalid, 0);
         awready = 1; wready = 1;
         @(negedge clk);                  // AW+W fire at T+1
         awready = 0; wready = 0;
         check($sformatf("v%0d aw/w drop", i), {awvalid, wvalid, wlast}, 0);
         check($sformatf("v%0d bready", i), bready, 1);
         bvalid = 1; bresp = v.sresp; bid = v.sid;
         @(negedge clk);                  // B fires at T+2
         bvalid = 0; bresp = 0; bid = 0;
         check($sformatf("v%0d bready drop", i), bready, 0);
      end
      check($sformatf("v%0d resp_valid", i), resp_valid, 1);
      check($sformatf("v%0d resp_rdata", i), resp_rdata, v.exp_rdata);
      check($sformatf("v%0d resp_err", i), resp_err, v.exp_err);
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
      check($sformatf("v%0d resp_valid drop", i), resp_valid, 0);
      check($sformatf("v%0d req_ready back", i), req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          wen addr          wdata         strb  sdata         resp  id    last exp_rdata     err
      vecs[0] = '{1'b0, 32'h1001_0000, 32'h0, 4'h0, 32'h0000_0123, 2'd0, 4'h0, 1'b1, 32'h0000_0123, 1'b0};
      vecs[1] = '{1'b0, 32'h1001_0008, 32'h0, 4'h0, 32'h0000_0000, 2'd2, 4'h0, 1'b1, 32'h0000_0000, 1'b1};
      vecs[2] = '{1'b0, 32'h1001_000C, 32'h0, 4'h0, 32'hCAFE_0001, 2'd0, 4'h1, 1'b1, 32'hCAFE_0001, 1'b1};
      vecs[3] = '{1'b0, 32'h1001_0010, 32'h0, 4'h0, 32'h1234_5678, 2'd0, 4'h0, 1'b0, 32'h1234_5678, 1'b1};
      vecs[4] = '{1'b0, 32'h0200_4000, 32'h0, 4'h0, 32'hA5A5_5A5A, 2'd1, 4'h0, 1'b1, 32'hA5A5_5A5A, 1'b0};
      vecs[5] = '{1'b1, 32'h2000_0004, 32'h1122_3344, 4'h3, 32'h0, 2'd0, 4'h0, 1'b1, 32'h0, 1'b0};
      vecs[6] = '{1'b1, 32'h2000_0008, 32'h5555_AAAA, 4'hF, 32'h0, 2'd0, 4'h5, 1'b1, 32'h0, 1'b1};
      vecs[7] = '{1'b1, 32'h2000_000C, 32'h0BAD_F00D, 4'h8, 32'h0, 2'd3, 4'h0, 1'b1, 32'h0, 1'b1};

      idle_inputs();
      rst = 1;
      #12;
      check("reset req_ready", req_ready, 1);
      check("reset valids", {arvalid, rready, awvalid, wvalid, wlast, bready, resp_valid, resp_err}, 0);
      check("reset araddr", araddr, 0);
      check("reset awaddr", awaddr, 0);
      check("reset wdata", wdata, 0);
      check("reset wstrb", wstrb, 0);
      check("reset resp_rdata", resp_rdata, 0);
      check("const ar fields", {arid, arlen, arsize, arburst}, {4'h0, 8'd0, 3'b010, 2'b01});
      check("const aw fields", {awid, awlen, awsize, awburst}, {4'h0, 8'd0, 3'b010, 2'b01});
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(i);

      // W handshake two cycles ahead of AW
      req_valid = 1; req_wen = 1; req_addr = 32'h1000_0000;
      req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
      @(negedge clk);
      req_valid = 0;
      wready = 1;
      @(negedge clk);
      wready = 0;
      check("wfirst wvalid drop", wvalid, 0);
      check("wfirst wlast drop", wlast, 0);
      check("wfirst awvalid held", awvalid, 1);
      check("wfirst bready low", bready, 0);
      bvalid = 1;                          // early B must be ignored
      @(negedge clk);
      bvalid = 0;
      check("wfirst awvalid held2", awvalid, 1);
      check("wfirst awaddr", awaddr, 32'h1000_0000);
      check("wfirst bready low2", bready, 0);
      check("wfirst no resp", resp_valid, 0);
      awready = 1;
      @(negedge clk);
      awready = 0;
      check("wfirst awvalid drop", awvalid, 0);
      check("wfirst bready", bready, 1);
      bvalid = 1;
      @(negedge clk);
      bvalid = 0;
      check("wfirst resp_valid", resp_valid, 1);
      check("wfirst resp_err", resp_err, 0);
      check("wfirst resp_rdata", resp_rdata, 0);
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
      check("wfirst req_ready", req_ready, 1);

      // AR back-pressure then response back-pressure
      req_valid = 1; req_wen = 0; req_addr = 32'h1001_0020;
      @(negedge clk);
      req_valid = 0;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d arvalid", c), arvalid, 1);
         check($sformatf("stall%0d araddr", c), araddr, 32'h1001_0020);
         check($sformatf("stall%0d rready", c), rready, 0);
         @(negedge clk);
      end
      arready = 1;
      @(negedge clk);
      arready = 0;
      rvalid = 1; rdata = 32'h0000_BEEF; rid = 4'h0; rlast = 1; rresp = 0;
      @(negedge clk);
      rvalid = 0; rdata = 0; rlast = 0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("hold%0d resp_valid", c), resp_valid, 1);
         check($sformatf("hold%0d resp_rdata", c), resp_rdata, 32'h0000_BEEF);
         check($sformatf("hold%0d req_ready", c), req_ready, 0);
         @(negedge clk);
      end
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
      check("hold released", resp_valid, 0);
      check("next req_ready", req_ready, 1);
      req_valid = 1; req_wen = 0; req_addr = 32'h1001_0030;
      @(negedge clk);
      req_valid = 0;
      check("next accepted", arvalid, 1);
      check("next araddr", araddr, 32'h1001_0030);
      arready = 1;
      @(negedge clk);
      arready = 0;
      check("pre-reset rready", rready, 1);

      // Asynchronous reset while waiting in RDATA
      rst = 1;
      #1;
      check("async rst rready", rready, 0);
      check("async rst req_ready", req_ready, 1);
      check("async rst araddr", araddr, 0);
      @(negedge clk);
      rst = 0;
      rvalid = 1; rdata = 32'hFFFF_FFFF; rlast = 1;   // stray beat
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("post-rst%0d resp_valid", c), resp_valid, 0);
         check($sformatf("post-rst%0d rready", c), rready, 0);
      end
      rvalid = 0; rdata = 0; rlast = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
